// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: one read (0x03) or write (0x02) of 1/2/4 bytes per request.
// sclk, cs and mosi come from registers clocked by clk; the sclk phase length comes from a down-counter.
module spi_mem_ctrl #(
  parameter int ADDR_WIDTH = 24,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  write,
  input  logic [1:0]            num_bytes,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);
  localparam int FW = 8 + ADDR_WIDTH + 32;
  localparam int CW = 16;
  localparam int BW = 7;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [BW-1:0] r_nbits;
  logic [FW-2:0] r_tx;
  logic [31:0]   r_rx;
  logic          r_write;

  logic [FW-1:0] w_frame;
  logic [BW-1:0] w_nbits;
  logic [4:0]    w_dbit;
  logic          w_data_ph;
  logic          w_last;

  // Data bytes go out little-endian. Reads send zeros in the data phase.
  assign w_frame   = {write ? 8'h02 : 8'h03, addr,
                      write ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0};
  assign w_nbits   = BW'(8 + ADDR_WIDTH) +
                     ((num_bytes == 2'd0) ? 7'd8 : (num_bytes == 2'd1) ? 7'd16 : 7'd32);
  assign w_dbit    = 5'(r_bit - BW'(8 + ADDR_WIDTH));
  assign w_data_ph = (r_bit >= BW'(8 + ADDR_WIDTH));
  assign w_last    = (r_bit == r_nbits - BW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_nbits <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_write <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            cs      <= 1'b0;
            busy    <= 1'b1;
            r_write <= write;
            r_nbits <= w_nbits;
            r_bit   <= '0;
            r_cnt   <= CW'(CS_SETUP - 1);
            mosi    <= w_frame[FW-1];
            r_tx    <= w_frame[FW-2:0];
            r_rx    <= '0;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_SHIFT;
            r_cnt   <= CW'(CLK_DIV - 1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!sclk) begin
            sclk  <= 1'b1;
            r_cnt <= CW'(CLK_DIV - 1);
            // Data-phase bit d is byte d/8, bit 7-d%8.
            if (!r_write && w_data_ph) r_rx[{w_dbit[4:3], ~w_dbit[2:0]}] <= miso;
          end else begin
            sclk <= 1'b0;
            if (w_last) begin
              r_state <= S_HOLD;
              r_cnt   <= CW'(CS_HOLD - 1);
              mosi    <= 1'b0;
            end else begin
              r_cnt <= CW'(CLK_DIV - 1);
              r_bit <= r_bit + BW'(1);
              mosi  <= r_tx[FW-2];
              r_tx  <= {r_tx[FW-3:0], 1'b0};
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            cs      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (!r_write) rdata <= r_rx;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: three parameter sets driven by a per-config SPI slave/reference model.
// Every transaction checks the mosi stream, the latency, the sclk phases and rdata against values derived from the frame layout.
module tb_spi_mem_ctrl;
  logic clk;
  int   n_chk = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int AW  = (g == 0) ? 24 : (g == 1) ? 16 : 32;
    localparam int DIV = (g == 0) ? 2  : (g == 1) ? 1  : 5;
    localparam int SU  = (g == 0) ? 4  : 1;
    localparam int HO  = (g == 0) ? 4  : 1;

    logic          rst_n, start, wr, busy, done, sclk, mosi, miso, cs, fin;
    logic [1:0]    nb;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;

    spi_mem_ctrl #(.ADDR_WIDTH(AW), .CLK_DIV(DIV), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .write(wr), .num_bytes(nb), .addr(addr),
      .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
      .miso(miso), .cs(cs)
    );

    task automatic ck(input string t, input logic [71:0] got, input logic [71:0] exp);
      chk($sformatf("cfg%0d_%s", g, t), got, exp);
    endtask

    // One transaction; optionally pulses start again at cycle 'poke' with junk inputs.
    task automatic xfer(input logic w, input logic [1:0] n, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rb, input int poke);
      int nby, bits, lat, rises, done_c, ndone, last_rise, last_fall, err, hi_err, idx, d;
      logic [71:0] exp_v, got_v, sl_v;
      logic [31:0] prev_rd, exp_rd, mask;
      logic [7:0]  cmd;
      logic        hi_mosi, prev_sclk, eb;
      nby  = (n == 2'd0) ? 1 : (n == 2'd1) ? 2 : 4;
      bits = 8 + AW + 8 * nby;
      lat  = SU + 2 * DIV * bits + HO;
      cmd  = w ? 8'h02 : 8'h03;
      exp_v = '0; sl_v = '0;
      for (int i = 0; i < bits; i++) begin
        if (i < 8) begin
          eb = cmd[7-i];
          sl_v = {sl_v[70:0], 1'($urandom)};
        end else if (i < 8 + AW) begin
          eb = a[AW-1-(i-8)];
          sl_v = {sl_v[70:0], 1'($urandom)};
        end else begin
          d   = i - 8 - AW;
          idx = 8 * (d / 8) + 7 - (d % 8);
          eb  = w ? wd[idx] : 1'b0;
          sl_v = {sl_v[70:0], rb[idx]};
        end
        exp_v = {exp_v[70:0], eb};
      end
      prev_rd = rdata;
      mask    = (nby == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nby)) - 32'h1);
      exp_rd  = w ? prev_rd : (rb & mask);

      @(negedge clk);
      start = 1'b1; wr = w; nb = n; addr = a[AW-1:0]; wdata = wd; miso = sl_v[bits-1];
      @(negedge clk);
      start = 1'b0; wr = 1'($urandom); nb = 2'($urandom); addr = AW'($urandom); wdata = $urandom;
      ck("acc_cs", 72'(cs), 72'(0));
      ck("acc_busy", 72'(busy), 72'(1));
      rises = 0; ndone = 0; done_c = -1; last_rise = 0; last_fall = 0; err = 0; hi_err = 0;
      got_v = '0; prev_sclk = 1'b0; hi_mosi = 1'b0;
      for (int c = 1; c <= lat + 2; c++) begin
        @(negedge clk);
        start = (poke > 0) && (c == poke);
        if (sclk && !prev_sclk) begin
          if (rises == 0) begin
            if (c != SU + DIV) err++;
          end else if (c - last_fall != DIV) err++;
          rises++; last_rise = c; hi_mosi = mosi; got_v = {got_v[70:0], mosi};
        end else if (!sclk && prev_sclk) begin
          if (c - last_rise != DIV) err++;
          last_fall = c;
          if (rises < bits) miso = sl_v[bits-1-rises];
        end else if (sclk && mosi !== hi_mosi) hi_err++;
        prev_sclk = sclk;
        if (done) begin
          ndone++; done_c = c;
          ck("done_cs", 72'(cs), 72'(1));
          ck("done_busy", 72'(busy), 72'(0));
          ck("done_rdata", 72'(rdata), 72'(exp_rd));
        end else if (c < lat && (cs || !busy)) err++;
      end
      ck("latency", 72'(done_c), 72'(lat));
      ck("ndone", 72'(ndone), 72'(1));
      ck("rises", 72'(rises), 72'(bits));
      ck("last_fall", 72'(last_fall), 72'(SU + 2 * DIV * bits));
      ck("phase_err", 72'(err), 72'(0));
      ck("mosi_hold", 72'(hi_err), 72'(0));
      ck("mosi_stream", w ? got_v : (got_v >> (8 * nby)), w ? exp_v : (exp_v >> (8 * nby)));
      ck("rdata_kept", 72'(rdata), 72'(exp_rd));
    endtask

    // start held high across two reads: exactly one cs-high cycle between them.
    task automatic held();
      int lat, ndone, cs_hi, d1, d2;
      lat = SU + 2 * DIV * (8 + AW + 32) + HO;
      @(negedge clk);
      start = 1'b1; wr = 1'b0; nb = 2'd2; addr = AW'($urandom); miso = 1'b0;
      ndone = 0; cs_hi = 0; d1 = -1; d2 = -1;
      for (int c = 0; c <= 2 * lat + 6; c++) begin
        @(negedge clk);
        if (done) begin
          ndone++;
          if (d1 < 0) d1 = c; else d2 = c;
        end
        if (c > 0 && c < 2 * lat + 1 && cs) cs_hi++;
        if (c == 2 * lat + 1) start = 1'b0;
      end
      ck("held_done1", 72'(d1), 72'(lat));
      ck("held_done2", 72'(d2), 72'(2 * lat + 1));
      ck("held_ndone", 72'(ndone), 72'(2));
      ck("held_cs_hi", 72'(cs_hi), 72'(1));
    endtask

    task automatic rst_mid();
      int nd;
      @(negedge clk);
      start = 1'b1; wr = 1'b0; nb = 2'd2; addr = AW'($urandom); miso = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      ck("arst_cs", 72'(cs), 72'(1));
      ck("arst_sclk", 72'(sclk), 72'(0));
      ck("arst_busy", 72'(busy), 72'(0));
      ck("arst_mosi", 72'(mosi), 72'(0));
      ck("arst_rdata", 72'(rdata), 72'(0));
      nd = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (c == 2) rst_n = 1'b1;
        if (done) nd++;
      end
      ck("arst_nodone", 72'(nd), 72'(0));
    endtask

    initial begin
      fin = 1'b0; rst_n = 1'b0; start = 1'b0; wr = 1'b0; nb = 2'd0;
      addr = '0; wdata = '0; miso = 1'b0;
      repeat (3) @(negedge clk);
      ck("rst_cs", 72'(cs), 72'(1));
      ck("rst_sclk", 72'(sclk), 72'(0));
      ck("rst_busy", 72'(busy), 72'(0));
      ck("rst_done", 72'(done), 72'(0));
      ck("rst_mosi", 72'(mosi), 72'(0));
      ck("rst_rdata", 72'(rdata), 72'(0));
      rst_n = 1'b1;
      xfer(1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h4433_2211, 0);
      xfer(1'b1, 2'd1, 32'h0000_00A0, 32'hDEAD_BEEF, $urandom, 0);
      xfer(1'b0, 2'd0, 32'h0000_1234, 32'h0, 32'hCCBB_AA5A, 0);
      xfer(1'b0, 2'd3, 32'h0000_0055, 32'h0, 32'h8765_4321, 0);
      xfer(1'b1, 2'd3, $urandom, $urandom, $urandom, 40);
      held();
      rst_mid();
      xfer(1'b0, 2'd2, $urandom, $urandom, $urandom, 0);
      for (int k = 0; k < 4; k++)
        xfer(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, (k == 1) ? 25 : 0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 90000 && !(cfg[0].fin && cfg[1].fin && cfg[2].fin); t++) @(posedge clk);
    chk("all_configs_finished", 72'({cfg[2].fin, cfg[1].fin, cfg[0].fin}), 72'(7));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
